pipelined_adder_nbits: RTL
==========================

Name: pipelined_adder_nbits

Overview:
- Parametrised, pipelined add/subtract unit; successor to the 16-bit combinational full adder.
- Splits a WIDTH-bit ripple-carry add into STAGES slices of CHUNK bits, one slice per pipeline stage.
- Carries a valid/ready handshake with backpressure and supports add or subtract per transaction.
- Sits in the datapath between operand registers and the writeback/result consumer.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits resolved per pipeline stage
STAGES, WIDTH/CHUNK (derived localparam, not overridable), pipeline depth and latency in cycles

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands valid this cycle
in_ready  output  1  unit accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
s  output  WIDTH  sum/difference
cout  output  1  carry-out; in subtract mode 1 = no borrow
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (async assert, sync release): all stage valid bits, out_valid, s, cout and ovf go to 0; all in-flight transactions are dropped.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational). The whole pipeline moves only when adv=1; otherwise every stage holds its value.
- Accept: in_valid && in_ready. When in_valid=0 and adv=1, a bubble (valid=0) enters stage 1.
- Operand preparation at entry:
  - add: B' = b, c0 = cin.
  - sub: B' = ~b, c0 = ~cin, so the result is a − b − cin.
- Stage k (1..STAGES) adds bits [k*CHUNK-1:(k-1)*CHUNK] of A and B' plus the carry from stage k−1, registers the partial sum, and forwards the unconsumed upper operand bits.
- Final stage registers:
  - s = full WIDTH result, modulo 2^WIDTH.
  - cout = carry out of the MSB.
  - ovf = carry into the MSB XOR carry out of the MSB.
- Latency: exactly STAGES cycles from acceptance to out_valid when out_ready is held high. Throughput: 1 result per cycle.
- Ordering is strictly in-order. No transaction is ever dropped or duplicated under any stall pattern.
- Simultaneous events: out_valid && out_ready && in_valid in the same cycle means the result retires and new operands are accepted in that cycle.
- Backpressure: while out_valid && !out_ready, s, cout and ovf stay stable and in_ready=0.
- Wrap-around: 0xFFFF + 0x0001 gives s=0x0000, cout=1 (WIDTH=16).
- Reset asserted mid-stream: outputs clear immediately. The first result after reset corresponds to the first operands accepted after release.

Optional Feature:
- Macro: PIPELINED_ADDER_SAT_EN.
- Defined: on signed overflow, s saturates instead of wrapping.
  - Positive overflow gives 2^(WIDTH-1)−1.
  - Negative overflow gives −2^(WIDTH-1).
  - ovf still reports the overflow; cout is unchanged.
- Undefined: s wraps modulo 2^WIDTH and no saturation logic is generated.

Decomposition:
- Shared package/include adder_pkg:
  - localparam-style constants for default WIDTH/CHUNK.
  - Mode encodings ADD=1'b0, SUB=1'b1.
  - Function computing STAGES with an elaboration-time check that WIDTH % CHUNK == 0.
- One sub-module, adder_slice: combinational CHUNK-bit ripple adder with ports a, b, cin, s, cout, plus carry-into-MSB for the overflow tap. Instantiated STAGES times via generate.
- pipelined_adder_nbits contains only the stage registers, handshake logic and optional saturation.

Test Plan (WIDTH=16, CHUNK=4):
- a=0x0001, b=0x0001, cin=0, sub=0, out_ready=1 -> s=0x0002, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> s=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> s=0x8000, ovf=1 (0x7FFF with SAT_EN).
- a=0x1234, b=0x1111, cin=0, sub=1 -> s=0x0123, cout=1; a=0x0000, b=0x0001, sub=1 -> s=0xFFFF, cout=0.
- Back-to-back stream of 8 transactions with out_ready toggling 1,0,0,1,… -> all 8 results in order; s stable while stalled; in_ready equals out_ready whenever out_valid=1.
- Assert rst with 3 transactions in flight -> out_valid=0 immediately, no stale result after release; next accepted 0x1234+0x1111 -> s=0x2345.
- 1000 random a/b/cin/sub with random out_ready -> every result matches a golden model (a±b±cin, cout, ovf, saturation when the macro is defined).

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants, mode encodings and the stage-count helper for the pipelined adder.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Returns 0 for an illegal split so the top can reject it at elaboration.
    function automatic int calc_stages(input int width, input int chunk);
        if ((chunk <= 0) || ((width % chunk) != 0)) begin
            return 0;
        end else begin
            return width / chunk;
        end
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit adder slice; c_msb is the carry into the slice's top bit,
// needed only by the most significant slice for signed-overflow detection.
module adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] total_s;

    assign total_s = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s       = total_s[CHUNK-1:0];
    assign cout    = total_s[CHUNK];
    // Recover the carry into the top bit from its sum bit.
    assign c_msb   = a[CHUNK-1] ^ b[CHUNK-1] ^ total_s[CHUNK-1];

endmodule

// File: rtl/pipelined_adder_nbits.sv
// Pipelined add/subtract unit, one CHUNK-bit slice per stage, valid/ready handshake.
// Define PIPELINED_ADDER_SAT_EN to saturate the result on signed overflow.
module pipelined_adder_nbits
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (STAGES < 1) begin : g_bad_cfg
        $error("pipelined_adder_nbits: WIDTH must be a positive multiple of CHUNK");
    end

    logic             adv_s;
    logic [WIDTH-1:0] entry_b_s;
    logic             entry_c_s;
    logic             last_valid_s;
    logic [WIDTH-1:0] final_sum_s;
    logic [WIDTH-1:0] result_s;
    logic             ovf_s;

    logic [CHUNK-1:0] slice_sum_s  [1:STAGES];
    logic             slice_cout_s [1:STAGES];
    logic             slice_cmsb_s [1:STAGES];

    logic             out_valid_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;

    // The whole pipeline moves in lockstep whenever the output slot can be vacated.
    assign adv_s    = !out_valid_r || out_ready;
    assign in_ready = adv_s;

    // Subtract is a + ~b + ~cin, giving a - b - cin.
    always_comb begin
        if (sub == SUB) begin
            entry_b_s = ~b;
            entry_c_s = ~cin;
        end else begin
            entry_b_s = b;
            entry_c_s = cin;
        end
    end

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        localparam int REM_IN = WIDTH - (k - 1) * CHUNK;

        logic [REM_IN-1:0] prev_a_s;
        logic [REM_IN-1:0] prev_b_s;
        logic              prev_c_s;

        if (k == 1) begin : g_src
            assign prev_a_s = a;
            assign prev_b_s = entry_b_s;
            assign prev_c_s = entry_c_s;
        end else begin : g_src
            assign prev_a_s = g_stage[k-1].g_reg.a_r;
            assign prev_b_s = g_stage[k-1].g_reg.b_r;
            assign prev_c_s = g_stage[k-1].g_reg.c_r;
        end

        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a     (prev_a_s[CHUNK-1:0]),
            .b     (prev_b_s[CHUNK-1:0]),
            .cin   (prev_c_s),
            .s     (slice_sum_s[k]),
            .cout  (slice_cout_s[k]),
            .c_msb (slice_cmsb_s[k])
        );

        // Only the operand bits still to be added travel forward; the sum grows per stage.
        if (k < STAGES) begin : g_reg
            localparam int REM_OUT = WIDTH - k * CHUNK;

            logic                 valid_r;
            logic                 c_r;
            logic [REM_OUT-1:0]   a_r;
            logic [REM_OUT-1:0]   b_r;
            logic [k*CHUNK-1:0]   sum_r;
            logic                 prev_valid_s;
            logic [k*CHUNK-1:0]   sum_next_s;

            if (k == 1) begin : g_acc
                assign prev_valid_s = in_valid;
                assign sum_next_s   = slice_sum_s[k];
            end else begin : g_acc
                assign prev_valid_s = g_stage[k-1].g_reg.valid_r;
                assign sum_next_s   = {slice_sum_s[k], g_stage[k-1].g_reg.sum_r};
            end

            // Stage register: loads on advance, holds otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_r <= 1'b0;
                    c_r     <= 1'b0;
                    a_r     <= {REM_OUT{1'b0}};
                    b_r     <= {REM_OUT{1'b0}};
                    sum_r   <= {(k*CHUNK){1'b0}};
                end else if (adv_s) begin
                    valid_r <= prev_valid_s;
                    c_r     <= slice_cout_s[k];
                    a_r     <= prev_a_s[REM_IN-1:CHUNK];
                    b_r     <= prev_b_s[REM_IN-1:CHUNK];
                    sum_r   <= sum_next_s;
                end
            end
        end
    end

    if (STAGES == 1) begin : g_last
        assign last_valid_s = in_valid;
        assign final_sum_s  = slice_sum_s[STAGES];
    end else begin : g_last
        assign last_valid_s = g_stage[STAGES-1].g_reg.valid_r;
        assign final_sum_s  = {slice_sum_s[STAGES], g_stage[STAGES-1].g_reg.sum_r};
    end

    assign ovf_s = slice_cmsb_s[STAGES] ^ slice_cout_s[STAGES];

`ifdef PIPELINED_ADDER_SAT_EN
    // A wrapped result with its sign bit set means the true value overflowed positive.
    always_comb begin
        if (ovf_s) begin
            if (final_sum_s[WIDTH-1]) begin
                result_s = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                result_s = {1'b1, {(WIDTH-1){1'b0}}};
            end
        end else begin
            result_s = final_sum_s;
        end
    end
`else
    assign result_s = final_sum_s;
`endif

    // Output register: stays frozen while the consumer withholds out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            s_r         <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= last_valid_s;
            s_r         <= result_s;
            cout_r      <= slice_cout_s[STAGES];
            ovf_r       <= ovf_s;
        end
    end

    assign out_valid = out_valid_r;
    assign s         = s_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule
